// File: rtl/axis_gearbox_pkg.sv
// Shared helpers for AXI-Stream byte packers: tkeep run-length decoding and count-to-mask expansion.
// Keep masks are handled zero-extended to MAX_KEEP_BYTES so one helper serves every bus width.
package axis_gearbox_pkg;

   localparam int MAX_KEEP_BYTES = 64;

   typedef logic [MAX_KEEP_BYTES-1:0] keep_t;

   // Length of the unbroken run of ones starting at bit 0.
   function automatic int trailing_ones(input keep_t keep);
      int   n;
      logic run;
      n   = 0;
      run = 1'b1;
      for (int i = 0; i < MAX_KEEP_BYTES; i++) begin
         run = run & keep[i];
         if (run) n = i + 1;
      end
      return n;
   endfunction

   // Low min(count, width) bits set.
   function automatic keep_t count_to_keep(input int count, input int width);
      keep_t m;
      m = '0;
      for (int i = 0; i < MAX_KEEP_BYTES; i++) begin
         if ((i < count) && (i < width)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_gearbox_if.sv
// AXI-Stream byte-lane bundle used on both sides of the gearbox; BYTES sets the tdata/tkeep width.
interface axis_gearbox_if #(
   parameter int BYTES = 1
);
   logic               tvalid;
   logic               tready;
   logic [8*BYTES-1:0] tdata;
   logic [BYTES-1:0]   tkeep;
   logic               tlast;

   modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_keep_decode.sv
// Combinational tkeep decoder: low-aligned byte count plus a flag for any enable above that run.
module axis_keep_decode
   import axis_gearbox_pkg::*;
#(
   parameter  int BYTES = 3,
   localparam int CNT_W = $clog2(BYTES + 1)
) (
   input  logic [BYTES-1:0] keep,
   output logic [CNT_W-1:0] count,
   output logic             noncontig
);
   keep_t keep_ext;
   keep_t run_mask;
   int    run_len;

   always_comb begin
      keep_ext              = '0;
      keep_ext[BYTES-1:0]   = keep;
      run_len               = trailing_ones(keep_ext);
      run_mask              = count_to_keep(run_len, BYTES);
      count                 = CNT_W'(run_len);
      noncontig             = (keep_ext & ~run_mask) != '0;
   end

endmodule

// File: rtl/axis_gearbox.sv
// Byte-compacting AXI-Stream width converter: enabled input bytes are appended to a shift buffer
// whose head drives the output beat directly, so output data always comes straight from flops.
module axis_gearbox
   import axis_gearbox_pkg::*;
#(
   parameter int AXIS_I_BYTES = 3,
   parameter int AXIS_O_BYTES = 2,
   parameter int EXTRA_BYTES  = 0
) (
   input  logic           clk,
   input  logic           areset,
   axis_gearbox_if.slave  axis_i,
   axis_gearbox_if.master axis_o,
   output logic           keep_err
);
   localparam int BUF_BYTES = AXIS_I_BYTES + AXIS_O_BYTES + EXTRA_BYTES;
   localparam int BUF_W     = 8 * BUF_BYTES;
   localparam int FILL_W    = $clog2(BUF_BYTES + 1);
   localparam int CNT_W     = $clog2(AXIS_I_BYTES + 1);
   localparam int IN_W      = 8 * AXIS_I_BYTES;
   localparam int OUT_W     = 8 * AXIS_O_BYTES;

   logic [BUF_W-1:0]        byte_buf_reg, byte_buf_next;
   logic [FILL_W-1:0]       fill_reg, fill_next;
   logic                    last_pending_reg, last_pending_next;
   logic                    zero_pkt_reg, zero_pkt_next;
   logic                    keep_err_reg;

   logic [CNT_W-1:0]        in_cnt;
   logic                    in_noncontig;
   logic [AXIS_I_BYTES-1:0] in_kmask;
   logic [IN_W-1:0]         in_bmask;
   logic [IN_W-1:0]         in_data;
   logic                    i_ready, o_valid, o_last;
   logic                    in_hs, out_hs;
   int                      pop_cnt, push_cnt, push_base;
   logic [BUF_W-1:0]        shifted, ins_mask, ins_data;

   axis_keep_decode #(
      .BYTES (AXIS_I_BYTES)
   ) u_keep_decode (
      .keep      (axis_i.tkeep),
      .count     (in_cnt),
      .noncontig (in_noncontig)
   );

   // Only the leading contiguous run of bytes is kept; stray enables above it are dropped.
   assign in_kmask = AXIS_I_BYTES'(count_to_keep(int'(in_cnt), AXIS_I_BYTES));

   genvar gi;
   generate
      for (gi = 0; gi < AXIS_I_BYTES; gi++) begin : g_in_mask
         assign in_bmask[8*gi +: 8] = {8{in_kmask[gi]}};
      end
   endgenerate

   assign in_data = axis_i.tdata & in_bmask;

   // Ready depends only on flops so there is no path from axis_o.tready to axis_i.tready.
   assign i_ready = !areset && !last_pending_reg
                    && ((int'(fill_reg) + AXIS_I_BYTES) <= BUF_BYTES);
   assign o_valid = (int'(fill_reg) >= AXIS_O_BYTES)
                    || (last_pending_reg && (fill_reg != '0))
                    || zero_pkt_reg;
   assign o_last  = last_pending_reg && (int'(fill_reg) <= AXIS_O_BYTES);

   assign axis_i.tready = i_ready;
   assign axis_o.tvalid = o_valid;
   assign axis_o.tlast  = o_last;
   assign axis_o.tdata  = byte_buf_reg[OUT_W-1:0];
   assign axis_o.tkeep  = AXIS_O_BYTES'(count_to_keep(int'(fill_reg), AXIS_O_BYTES));
   assign keep_err      = keep_err_reg;

   assign in_hs  = axis_i.tvalid && i_ready;
   assign out_hs = o_valid && axis_o.tready;

   always_comb begin
      pop_cnt = 0;
      if (out_hs) begin
         pop_cnt = (int'(fill_reg) < AXIS_O_BYTES) ? int'(fill_reg) : AXIS_O_BYTES;
      end
      push_cnt  = in_hs ? int'(in_cnt) : 0;
      // New bytes land right after whatever survives this cycle's pop.
      push_base = int'(fill_reg) - pop_cnt;

      shifted   = byte_buf_reg >> (8 * pop_cnt);
      ins_mask  = in_hs ? (BUF_W'(in_bmask) << (8 * push_base)) : '0;
      ins_data  = BUF_W'(in_data) << (8 * push_base);

      byte_buf_next = (shifted & ~ins_mask) | (ins_data & ins_mask);
      fill_next     = FILL_W'(push_base + push_cnt);

      last_pending_next = last_pending_reg;
      zero_pkt_next     = zero_pkt_reg;
      if (out_hs && o_last) begin
         last_pending_next = 1'b0;
         zero_pkt_next     = 1'b0;
      end
      // Input is blocked while last_pending, so this never collides with the clear above.
      if (in_hs && axis_i.tlast) begin
         last_pending_next = 1'b1;
         zero_pkt_next     = (fill_next == '0);
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         byte_buf_reg     <= '0;
         fill_reg         <= '0;
         last_pending_reg <= 1'b0;
         zero_pkt_reg     <= 1'b0;
         keep_err_reg     <= 1'b0;
      end else begin
         byte_buf_reg     <= byte_buf_next;
         fill_reg         <= fill_next;
         last_pending_reg <= last_pending_next;
         zero_pkt_reg     <= zero_pkt_next;
         keep_err_reg     <= in_hs && in_noncontig;
      end
   end

endmodule
